// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared encodings, controller states, default latencies and a small sign helper
// for the HI/LO multiply/divide sequencer.
package muldiv_hilo_ctrl_pkg;

    // Operation encodings presented by EX
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // Default latencies
    localparam int MUL_LAT_DEF  = 2;
    localparam int DIV_ITER_DEF = 32;

    // Two's-complement negate when neg is set; used for |x| and sign fixup
    function automatic logic [31:0] neg_if(input logic [31:0] val, input logic neg);
        logic [31:0] res;
        if (neg) begin
            res = 32'd0 - val;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX <-> multiply/divide unit request and HI/LO result bundle.
interface muldiv_hilo_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // EX side: issues ops, observes busy/done/HI/LO
    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, done, hi, lo
    );

    // Unit side
    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_ctrl_div_iter_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes: one shift-subtract
// step per cycle while step is high. Sign handling and sequencing live outside.
module muldiv_hilo_ctrl_div_iter_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dsr_r;
    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        rem_sh_s = {rem_r, quo_r[31]};
        diff_s   = rem_sh_s - {1'b0, dsr_r};
    end

    // Load operands, then shift in one quotient bit per step (restore on borrow)
    always_ff @(posedge clk) begin
        if (!rst) begin
            quo_r <= 32'd0;
            rem_r <= 32'd0;
            dsr_r <= 32'd0;
        end else if (load) begin
            quo_r <= dividend;
            rem_r <= 32'd0;
            dsr_r <= divisor;
        end else if (step) begin
            if (!diff_s[32]) begin
                rem_r <= diff_s[31:0];
            end else begin
                rem_r <= rem_sh_s[31:0];
            end
            quo_r <= {quo_r[30:0], ~diff_s[32]};
        end else begin
            quo_r <= quo_r;
            rem_r <= rem_r;
            dsr_r <= dsr_r;
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO. busy feeds the
// stall unit; cancel drops an in-flight op without disturbing HI/LO.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int DIV_ITER = DIV_ITER_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    muldiv_hilo_ctrl_if.slave    bus
);

    localparam int CNT_W = $clog2(DIV_ITER + MUL_LAT + 1);

    logic [1:0]        state_r, state_nx;
    logic [CNT_W-1:0]  cnt_r, cnt_nx;
    logic [31:0]       hi_r, hi_nx;
    logic [31:0]       lo_r, lo_nx;
    logic              busy_r;
    logic              done_r, done_nx;
    logic              mul_load_s;
    logic              div_load_s;
    logic              is_signed_s;

    logic signed [32:0] mul_a_r, mul_b_r;
    logic signed [63:0] mul_prod_s;
    logic [63:0]        prod_r;
    logic [63:0]        mul_res_s;

    logic        div_sa_r, div_sb_r;
    logic [31:0] core_q_s, core_r_s;
    logic [31:0] quot_fix_s, rem_fix_s;

    // Sign-extended 33x33 product of the latched operands; with MUL_LAT==1 it
    // is consumed directly, otherwise through the product register
    always_comb begin
        mul_prod_s = 64'(mul_a_r) * 64'(mul_b_r);
        if (MUL_LAT == 1) begin
            mul_res_s = mul_prod_s;
        end else begin
            mul_res_s = prod_r;
        end
    end

    // Signedness of the requested op and signed-division result fixup
    always_comb begin
        is_signed_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        quot_fix_s  = neg_if(core_q_s, div_sa_r ^ div_sb_r);
        rem_fix_s   = neg_if(core_r_s, div_sa_r);
    end

    // Next-state, counter and HI/LO update decisions; cancel overrides all
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        hi_nx      = hi_r;
        lo_nx      = lo_r;
        done_nx    = 1'b0;
        mul_load_s = 1'b0;
        div_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OP_MTHI: hi_nx = bus.src_a;
                        OP_MTLO: lo_nx = bus.src_a;
                        OP_MULT, OP_MULTU: begin
                            mul_load_s = 1'b1;
                            cnt_nx     = CNT_W'(MUL_LAT - 1);
                            state_nx   = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.src_b == 32'd0) begin
                                done_nx = 1'b1;
                            end else begin
                                div_load_s = 1'b1;
                                cnt_nx     = CNT_W'(DIV_ITER - 1);
                                state_nx   = ST_DIV;
                            end
                        end
                        default: state_nx = ST_IDLE;
                    endcase
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (bus.cancel) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = {CNT_W{1'b0}};
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    {hi_nx, lo_nx} = mul_res_s;
                    done_nx        = 1'b1;
                    state_nx       = ST_IDLE;
                end else begin
                    cnt_nx = cnt_r - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (bus.cancel) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = {CNT_W{1'b0}};
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nx = ST_FIX;
                end else begin
                    cnt_nx = cnt_r - CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (bus.cancel) begin
                    state_nx = ST_IDLE;
                end else begin
                    lo_nx    = quot_fix_s;
                    hi_nx    = rem_fix_s;
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control and architectural registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            hi_r    <= hi_nx;
            lo_r    <= lo_nx;
            busy_r  <= (state_nx != ST_IDLE);
            done_r  <= done_nx;
        end
    end

    // Multiplier operand latch and product pipeline register
    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_a_r <= 33'sd0;
            mul_b_r <= 33'sd0;
            prod_r  <= 64'd0;
        end else if (mul_load_s) begin
            mul_a_r <= {is_signed_s & bus.src_a[31], bus.src_a};
            mul_b_r <= {is_signed_s & bus.src_b[31], bus.src_b};
            prod_r  <= prod_r;
        end else begin
            prod_r  <= mul_prod_s;
        end
    end

    // Division sign flags captured at issue
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_sa_r <= 1'b0;
            div_sb_r <= 1'b0;
        end else if (div_load_s) begin
            div_sa_r <= is_signed_s & bus.src_a[31];
            div_sb_r <= is_signed_s & bus.src_b[31];
        end else begin
            div_sa_r <= div_sa_r;
            div_sb_r <= div_sb_r;
        end
    end

    muldiv_hilo_ctrl_div_iter_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load_s),
        .step      (state_r == ST_DIV),
        .dividend  (neg_if(bus.src_a, is_signed_s & bus.src_a[31])),
        .divisor   (neg_if(bus.src_b, is_signed_s & bus.src_b[31])),
        .quotient  (core_q_s),
        .remainder (core_r_s)
    );

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl with default MUL_LAT=2, DIV_ITER=32.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   nbusy;
    logic seen_done;

    muldiv_hilo_ctrl_if bus_if ();

    muldiv_hilo_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single edge; returns at the negedge after that edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.src_a = a;
        bus_if.src_b = b;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    // Count busy cycles (bounded), stopping at the first idle negedge
    task automatic wait_idle(output int n);
        n = 0;
        while (bus_if.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.op     = 3'd0;
        bus_if.src_a  = 32'd0;
        bus_if.src_b  = 32'd0;
        bus_if.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_hi", bus_if.hi, 32'd0);
        check("rst_lo", bus_if.lo, 32'd0);
        rst = 1'b1;

        // MTHI / MTLO
        issue(OP_MTHI, 32'h0000_0011, 32'd0);
        check("mthi_hi", bus_if.hi, 32'h0000_0011);
        check("mthi_busy", 32'(bus_if.busy), 32'd0);
        issue(OP_MTLO, 32'h0000_0022, 32'd0);
        check("mtlo_lo", bus_if.lo, 32'h0000_0022);
        check("mtlo_done", 32'(bus_if.done), 32'd0);

        // DIVU by zero: done pulse, no busy, HI/LO kept
        issue(OP_DIVU, 32'd5, 32'd0);
        check("dz_busy", 32'(bus_if.busy), 32'd0);
        check("dz_done", 32'(bus_if.done), 32'd1);
        check("dz_hi", bus_if.hi, 32'h0000_0011);
        check("dz_lo", bus_if.lo, 32'h0000_0022);
        @(negedge clk);
        check("dz_done_end", 32'(bus_if.done), 32'd0);

        // MULT -1*2, with an MTLO attempted while busy
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        check("mult_busy1", 32'(bus_if.busy), 32'd1);
        bus_if.start = 1'b1;
        bus_if.op    = OP_MTLO;
        bus_if.src_a = 32'h0000_0099;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("mult_busy2", 32'(bus_if.busy), 32'd1);
        check("mult_done_early", 32'(bus_if.done), 32'd0);
        @(negedge clk);
        check("mult_busy_end", 32'(bus_if.busy), 32'd0);
        check("mult_done", 32'(bus_if.done), 32'd1);
        check("mult_hi", bus_if.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus_if.lo, 32'hFFFF_FFFE);
        @(negedge clk);
        check("mult_done_pulse", 32'(bus_if.done), 32'd0);

        // MULTU 0xFFFFFFFF*2
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(nbusy);
        check("multu_cycles", 32'(nbusy), 32'd2);
        check("multu_hi", bus_if.hi, 32'h0000_0001);
        check("multu_lo", bus_if.lo, 32'hFFFF_FFFE);

        // DIV -7/2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(nbusy);
        check("div_cycles", 32'(nbusy), 32'd33);
        check("div_done", 32'(bus_if.done), 32'd1);
        check("div_lo", bus_if.lo, 32'hFFFF_FFFD);
        check("div_hi", bus_if.hi, 32'hFFFF_FFFF);

        // DIVU 100/7
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(nbusy);
        check("divu_lo", bus_if.lo, 32'd14);
        check("divu_hi", bus_if.hi, 32'd2);

        // DIV 7/-2: remainder follows dividend sign
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle(nbusy);
        check("divn_lo", bus_if.lo, 32'hFFFF_FFFD);
        check("divn_hi", bus_if.hi, 32'd1);

        // Signed overflow
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(nbusy);
        check("ovf_lo", bus_if.lo, 32'h8000_0000);
        check("ovf_hi", bus_if.hi, 32'd0);

        // Cancel a DIV at busy cycle 10
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        check("cxl_busy_before", 32'(bus_if.busy), 32'd1);
        bus_if.cancel = 1'b1;
        @(negedge clk);
        bus_if.cancel = 1'b0;
        check("cxl_busy", 32'(bus_if.busy), 32'd0);
        seen_done = bus_if.done;
        repeat (40) begin
            @(negedge clk);
            seen_done = seen_done | bus_if.done;
        end
        check("cxl_no_done", 32'(seen_done), 32'd0);
        check("cxl_hi", bus_if.hi, 32'd0);
        check("cxl_lo", bus_if.lo, 32'h8000_0000);
        issue(OP_MTLO, 32'd5, 32'd0);
        check("cxl_mtlo_lo", bus_if.lo, 32'd5);
        check("cxl_mtlo_busy", 32'(bus_if.busy), 32'd0);

        // Cancel in IDLE blocks an MTHI
        @(negedge clk);
        bus_if.cancel = 1'b1;
        bus_if.start  = 1'b1;
        bus_if.op     = OP_MTHI;
        bus_if.src_a  = 32'h0000_00AA;
        @(negedge clk);
        bus_if.cancel = 1'b0;
        bus_if.start  = 1'b0;
        check("idle_cxl_hi", bus_if.hi, 32'd0);

        // Cancel coincident with the completing MULT edge
        issue(OP_MULT, 32'd3, 32'd4);
        @(negedge clk);
        bus_if.cancel = 1'b1;
        @(negedge clk);
        bus_if.cancel = 1'b0;
        check("cend_busy", 32'(bus_if.busy), 32'd0);
        check("cend_done", 32'(bus_if.done), 32'd0);
        check("cend_lo", bus_if.lo, 32'd5);
        @(negedge clk);
        check("cend_done_late", 32'(bus_if.done), 32'd0);
        check("cend_hi", bus_if.hi, 32'd0);

        // Undefined op ignored
        issue(3'd6, 32'h0000_0077, 32'd1);
        check("undef_busy", 32'(bus_if.busy), 32'd0);
        check("undef_lo", bus_if.lo, 32'd5);

        // Reset mid-MUL
        issue(OP_MULTU, 32'd3, 32'd5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rmid_busy", 32'(bus_if.busy), 32'd0);
        check("rmid_lo", bus_if.lo, 32'd0);
        check("rmid_done", 32'(bus_if.done), 32'd0);
        @(negedge clk);
        check("rmid_done_late", 32'(bus_if.done), 32'd0);

        // MULTU after reset: 0x10000 * 0x10000
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_idle(nbusy);
        check("post_hi", bus_if.hi, 32'd1);
        check("post_lo", bus_if.lo, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
